// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_stage
// Purpose  : RV32 register file plus R-type operand fetch; one output slot with
//            valid/ready handshake. Build macro ALU_OPERAND_IMM_EN adds OP-IMM.
// Revision : 1.0 - initial release
// ============================================================================
module alu_operand_stage #(
   parameter int REG_COUNT = 32
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] inst_i,
   input  logic        inst_valid_i,
   output logic        inst_ready_o,
   input  logic        wb_en_i,
   input  logic [4:0]  wb_rd_i,
   input  logic [31:0] wb_data_i,
   output logic [31:0] rs1_o,
   output logic [31:0] rs2_o,
   output logic [3:0]  AluOp_o,
   output logic [4:0]  rd_o,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic        illegal_o
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] F7_ZERO    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;

   // x0 has no storage; it is synthesised as a constant on the read side.
   logic [31:0] regs_q [1:REG_COUNT-1];

   logic [31:0] rs1_q, rs1_d;
   logic [31:0] rs2_q, rs2_d;
   logic [3:0]  aluop_q, aluop_d;
   logic [4:0]  rd_q, rd_d;
   logic        valid_q, valid_d;
   logic        illegal_q, illegal_d;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [4:0]  rs1_idx;
   logic [4:0]  rs2_idx;
   logic [31:0] rs1_rd;
   logic [31:0] rs2_rd;
   logic [31:0] rs2_sel;
   logic [3:0]  aluop_dec;
   logic        legal;
   logic        accept;

   assign opcode  = inst_i[6:0];
   assign funct3  = inst_i[14:12];
   assign funct7  = inst_i[31:25];
   assign rs1_idx = inst_i[19:15];
   assign rs2_idx = inst_i[24:20];

   assign inst_ready_o = !valid_q || out_ready_i;
   assign accept       = inst_valid_i && inst_ready_o;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 1; i < REG_COUNT; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 1; i < REG_COUNT; i++) begin
            if (wb_en_i && (wb_rd_i == 5'(i))) begin
               regs_q[i] <= wb_data_i;
            end
         end
      end
   end

   // Writeback in the same cycle as the read wins, so the operand is never stale.
   always_comb begin
      rs1_rd = '0;
      rs2_rd = '0;
      for (int i = 1; i < REG_COUNT; i++) begin
         if (rs1_idx == 5'(i)) begin
            rs1_rd = (wb_en_i && (wb_rd_i == rs1_idx)) ? wb_data_i : regs_q[i];
         end
         if (rs2_idx == 5'(i)) begin
            rs2_rd = (wb_en_i && (wb_rd_i == rs2_idx)) ? wb_data_i : regs_q[i];
         end
      end
   end

   always_comb begin
      legal     = 1'b0;
      aluop_dec = {inst_i[30], funct3};
      rs2_sel   = rs2_rd;
      if (opcode == OPC_OP) begin
         legal = (funct7 == F7_ZERO) ||
                 ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
`ifdef ALU_OPERAND_IMM_EN
      else if (opcode == OPC_OP_IMM) begin
         rs2_sel = {{20{inst_i[31]}}, inst_i[31:20]};
         case (funct3)
            3'b001:  legal = (funct7 == F7_ZERO);
            3'b101:  legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
            default: legal = 1'b1;
         endcase
         aluop_dec = (funct3 == 3'b101) ? {inst_i[30], 3'b101} : {1'b0, funct3};
      end
`endif
   end

   always_comb begin
      rs1_d     = rs1_q;
      rs2_d     = rs2_q;
      aluop_d   = aluop_q;
      rd_d      = rd_q;
      valid_d   = valid_q && !out_ready_i;
      illegal_d = accept && !legal;
      if (accept && legal) begin
         rs1_d   = rs1_rd;
         rs2_d   = rs2_sel;
         aluop_d = aluop_dec;
         rd_d    = inst_i[11:7];
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rs1_q     <= '0;
         rs2_q     <= '0;
         aluop_q   <= '0;
         rd_q      <= '0;
         valid_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         rs1_q     <= rs1_d;
         rs2_q     <= rs2_d;
         aluop_q   <= aluop_d;
         rd_q      <= rd_d;
         valid_q   <= valid_d;
         illegal_q <= illegal_d;
      end
   end

   assign rs1_o       = rs1_q;
   assign rs2_o       = rs2_q;
   assign AluOp_o     = aluop_q;
   assign rd_o        = rd_q;
   assign out_valid_o = valid_q;
   assign illegal_o   = illegal_q;

endmodule
`default_nettype wire
